// File: rtl/multicycle_dp_pkg.sv
// Shared types for the multicycle datapath: FSM states, alu_op/func_code encodings
// and the internal ALU control decode.
package multicycle_dp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EX,
    ST_MEM,
    ST_WB
  } state_e;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_SLT  = 2'b11;

  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_NOR = 6'h27;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_ZERO
  } alu_ctrl_e;

  // Unknown function codes map to ALU_ZERO so the result is a defined 0.
  function automatic alu_ctrl_e aluDecode(input logic [1:0] aluOp, input logic [5:0] func);
    alu_ctrl_e ctrl;
    ctrl = ALU_ZERO;
    case (aluOp)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_SLT: ctrl = ALU_SLT;
      default: begin
        case (func)
          FUNC_ADD: ctrl = ALU_ADD;
          FUNC_SUB: ctrl = ALU_SUB;
          FUNC_AND: ctrl = ALU_AND;
          FUNC_OR:  ctrl = ALU_OR;
          FUNC_NOR: ctrl = ALU_NOR;
          FUNC_SLT: ctrl = ALU_SLT;
          default:  ctrl = ALU_ZERO;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/multicycle_alu.sv
// Combinational ALU control decode plus ALU; add/sub wrap, slt is a signed compare.
module multicycle_alu
  import multicycle_dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        alu_op_i,
  input  logic [5:0]        func_code_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  alu_ctrl_e ctrl;

  assign ctrl = aluDecode(alu_op_i, func_code_i);

  always_comb begin
    result_o = '0;
    case (ctrl)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_dp_rf_alu.sv
// Multicycle datapath: register file, ALU, sign extender and word memory,
// executing one latched instruction per start/done handshake (RD -> EX -> [MEM] -> [WB]).
module multicycle_dp_rf_alu
  import multicycle_dp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [15:0]       imm_i,
  input  logic [5:0]        func_code_i,
  input  logic [1:0]        alu_op_i,
  input  logic              reg_dst_i,
  input  logic              alu_src_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              zero_o,
  output logic [DATA_W-1:0] alu_out_o
);

  localparam int NREGS  = 2**REG_AW;
  localparam int NWORDS = 2**MEM_AW;

  state_e state_q, state_d;
  logic done_q, done_d;

  logic [REG_AW-1:0] rs_q, rt_q, rd_q;
  logic [15:0]       imm_q;
  logic [5:0]        func_q;
  logic [1:0]        aluOp_q;
  logic regDst_q, aluSrc_q, memWrite_q, memRead_q, memToReg_q, regWrite_q;

  logic [DATA_W-1:0] opA_q, opB_q, aluOut_q, loadData_q;
  logic              zero_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] mem_q  [NWORDS];

  logic              accept;
  logic [DATA_W-1:0] sextImm, aluResult, rsData, rtData, wbData;
  logic [REG_AW-1:0] wbDest;
  logic [MEM_AW-1:0] memAddr;

  assign accept  = (state_q == ST_IDLE) && start_i;
  assign sextImm = {{(DATA_W-16){imm_q[15]}}, imm_q};
  assign rsData  = (rs_q == '0) ? '0 : regs_q[rs_q];
  assign rtData  = (rt_q == '0) ? '0 : regs_q[rt_q];
  assign wbDest  = regDst_q ? rd_q : rt_q;
  assign wbData  = memToReg_q ? loadData_q : aluOut_q;
  assign memAddr = aluOut_q[MEM_AW+1:2];

  multicycle_alu #(.DATA_W(DATA_W)) uAlu (
    .alu_op_i   (aluOp_q),
    .func_code_i(func_q),
    .a_i        (opA_q),
    .b_i        (opB_q),
    .result_o   (aluResult)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // done is registered so it appears in the first IDLE cycle after the last active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RD;
      ST_RD:   state_d = ST_EX;
      ST_EX: begin
        if (memRead_q || memWrite_q) state_d = ST_MEM;
        else if (regWrite_q)         state_d = ST_WB;
        else                         state_d = ST_IDLE;
      end
      ST_MEM:  state_d = regWrite_q ? ST_WB : ST_IDLE;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs_q <= '0; rt_q <= '0; rd_q <= '0;
      imm_q <= '0; func_q <= '0; aluOp_q <= '0;
      regDst_q <= 1'b0; aluSrc_q <= 1'b0; memWrite_q <= 1'b0;
      memRead_q <= 1'b0; memToReg_q <= 1'b0; regWrite_q <= 1'b0;
      opA_q <= '0; opB_q <= '0; aluOut_q <= '0; zero_q <= 1'b0;
      loadData_q <= '0;
    end else begin
      if (accept) begin
        rs_q <= rs_i; rt_q <= rt_i; rd_q <= rd_i;
        imm_q <= imm_i; func_q <= func_code_i; aluOp_q <= alu_op_i;
        regDst_q <= reg_dst_i; aluSrc_q <= alu_src_i; memWrite_q <= mem_write_i;
        memRead_q <= mem_read_i; memToReg_q <= mem_to_reg_i; regWrite_q <= reg_write_i;
      end
      case (state_q)
        ST_RD: begin
          opA_q <= rsData;
          opB_q <= aluSrc_q ? sextImm : rtData;
        end
        ST_EX: begin
          aluOut_q <= aluResult;
          zero_q   <= (aluResult == '0);
        end
        // A combined read+write request performs only the store.
        ST_MEM: if (memRead_q && !memWrite_q) loadData_q <= mem_q[memAddr];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (state_q == ST_WB && regWrite_q && wbDest != '0) begin
      regs_q[wbDest] <= wbData;
    end
  end

  // Memory has no reset; a reset during MEM leaves state_q in IDLE so the store never lands.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_MEM && memWrite_q) mem_q[memAddr] <= rtData;
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign zero_o    = zero_q;
  assign alu_out_o = aluOut_q;

endmodule

// File: tb/tb_multicycle_dp_rf_alu.sv
// Self-checking bench for multicycle_dp_rf_alu: directed scenarios plus random
// instructions compared against an instruction-level reference model.
module tb_multicycle_dp_rf_alu;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  func;
    logic [1:0]  aluOp;
    logic regDst, aluSrc, memWrite, memRead, memToReg, regWrite;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [5:0]  funcCode;
  logic [1:0]  aluOp;
  logic        regDst, aluSrc, memWrite, memRead, memToReg, regWrite;
  logic        busy, done, zero;
  logic [31:0] aluOut;

  int total = 0;
  int bad   = 0;

  logic [31:0] refReg [32];
  logic [31:0] refMem [256];
  bit          memValid [256];
  logic [31:0] loadRef;

  always #5 clk = ~clk;

  multicycle_dp_rf_alu dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .rs_i(rs), .rt_i(rt), .rd_i(rd), .imm_i(imm), .func_code_i(funcCode),
    .alu_op_i(aluOp), .reg_dst_i(regDst), .alu_src_i(aluSrc),
    .mem_write_i(memWrite), .mem_read_i(memRead), .mem_to_reg_i(memToReg),
    .reg_write_i(regWrite),
    .busy_o(busy), .done_o(done), .zero_o(zero), .alu_out_o(aluOut)
  );

  function automatic instr_t mkAddi(input int dst, input int src, input logic [15:0] im);
    instr_t i;
    i = '0; i.rt = dst[4:0]; i.rs = src[4:0]; i.imm = im;
    i.aluOp = 2'b00; i.aluSrc = 1'b1; i.regWrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkR(input int dst, input int s1, input int s2, input logic [5:0] f);
    instr_t i;
    i = '0; i.rd = dst[4:0]; i.rs = s1[4:0]; i.rt = s2[4:0]; i.func = f;
    i.aluOp = 2'b10; i.regDst = 1'b1; i.regWrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkView(input int r);
    instr_t i;
    i = mkR(0, r, 0, 6'h20);
    i.regWrite = 1'b0;
    return i;
  endfunction

  function automatic instr_t mkSw(input int src, input logic [15:0] addr);
    instr_t i;
    i = '0; i.rt = src[4:0]; i.imm = addr; i.aluSrc = 1'b1; i.memWrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkLw(input int dst, input logic [15:0] addr);
    instr_t i;
    i = '0; i.rt = dst[4:0]; i.imm = addr; i.aluSrc = 1'b1;
    i.memRead = 1'b1; i.memToReg = 1'b1; i.regWrite = 1'b1;
    return i;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 32; k++) refReg[k] = 32'd0;
    loadRef = 32'd0;
  endtask

  // Instruction-level model: operands, result, memory effect, writeback, latency.
  task automatic refExec(input instr_t i, output logic [31:0] expAlu, output logic expZero,
                         output int expLat);
    logic [31:0] a, b, r;
    int w, dst;
    a = refReg[i.rs];
    b = i.aluSrc ? {{16{i.imm[15]}}, i.imm} : refReg[i.rt];
    r = 32'd0;
    case (i.aluOp)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b11: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        case (i.func)
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h27: r = ~(a | b);
          6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: r = 32'd0;
        endcase
      end
    endcase
    w = int'((r / 4) % 256);
    if (i.memWrite) begin
      refMem[w] = refReg[i.rt];
      memValid[w] = 1'b1;
    end else if (i.memRead) begin
      loadRef = refMem[w];
    end
    dst = i.regDst ? int'(i.rd) : int'(i.rt);
    if (i.regWrite && dst != 0) refReg[dst] = i.memToReg ? loadRef : r;
    expAlu  = r;
    expZero = (r == 32'd0);
    expLat  = 3 + ((i.memRead || i.memWrite) ? 1 : 0) + (i.regWrite ? 1 : 0);
  endtask

  task automatic startOp(input instr_t i);
    rs = i.rs; rt = i.rt; rd = i.rd; imm = i.imm; funcCode = i.func; aluOp = i.aluOp;
    regDst = i.regDst; aluSrc = i.aluSrc; memWrite = i.memWrite; memRead = i.memRead;
    memToReg = i.memToReg; regWrite = i.regWrite;
    start = 1'b1;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (done !== 1'b1 && lat < 20);
  endtask

  task automatic runOp(input instr_t i, output int lat);
    startOp(i);
    waitDone(lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    startOp('0); start = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    total++; if (aluOut !== 32'd0) begin bad++; $display("FAIL reset_alu got=%h want=0", aluOut); end
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_rtype_add();
    instr_t ops [4];
    logic [31:0] ea; logic ez; int el, lat;
    ops[0] = mkAddi(1, 0, 16'd5);
    ops[1] = mkAddi(2, 0, 16'd7);
    ops[2] = mkR(3, 1, 2, 6'h20);
    ops[3] = mkView(3);
    for (int k = 0; k < 4; k++) begin
      refExec(ops[k], ea, ez, el);
      runOp(ops[k], lat);
      total++; if (lat !== el) begin bad++; $display("FAIL add_lat op%0d got=%0d want=%0d", k, lat, el); end
      total++; if (aluOut !== ea) begin bad++; $display("FAIL add_alu op%0d got=%h want=%h", k, aluOut, ea); end
      total++; if (zero !== ez) begin bad++; $display("FAIL add_zero op%0d got=%b want=%b", k, zero, ez); end
    end
    total++; if (aluOut !== 32'd12) begin bad++; $display("FAIL add_r3_value got=%h want=c", aluOut); end
  endtask

  task automatic test_r0_write();
    logic [31:0] ea; logic ez; int el, lat;
    refExec(mkAddi(0, 0, 16'd9), ea, ez, el);
    runOp(mkAddi(0, 0, 16'd9), lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL r0_lat got=%0d want=4", lat); end
    total++; if (aluOut !== 32'd9) begin bad++; $display("FAIL r0_addi_alu got=%h want=9", aluOut); end
    refExec(mkR(10, 0, 0, 6'h20), ea, ez, el);
    runOp(mkR(10, 0, 0, 6'h20), lat);
    total++; if (aluOut !== 32'd0) begin bad++; $display("FAIL r0_read_alu got=%h want=0", aluOut); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL r0_read_zero got=%b want=1", zero); end
  endtask

  task automatic test_store_load();
    instr_t i;
    logic [31:0] ea; logic ez; int el, lat;
    i = mkAddi(4, 0, 16'hDEAE); refExec(i, ea, ez, el); runOp(i, lat);
    for (int k = 0; k < 16; k++) begin
      i = mkR(4, 4, 4, 6'h20); refExec(i, ea, ez, el); runOp(i, lat);
    end
    i = mkAddi(4, 4, 16'hBEEF); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (aluOut !== 32'hDEADBEEF) begin bad++; $display("FAIL build_r4 got=%h want=deadbeef", aluOut); end
    i = mkSw(4, 16'h0010); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL sw_lat got=%0d want=4", lat); end
    total++; if (aluOut !== 32'h10) begin bad++; $display("FAIL sw_addr got=%h want=10", aluOut); end
    i = mkLw(5, 16'h0010); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL lw_lat got=%0d want=5", lat); end
    i = mkView(5); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (aluOut !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_r5 got=%h want=deadbeef", aluOut); end
  endtask

  task automatic test_slt();
    instr_t i;
    logic [31:0] ea; logic ez; int el, lat;
    i = mkAddi(6, 0, 16'hFFFF); refExec(i, ea, ez, el); runOp(i, lat);
    i = mkAddi(7, 0, 16'h0001); refExec(i, ea, ez, el); runOp(i, lat);
    i = mkR(0, 6, 7, 6'h2A); i.regWrite = 1'b0;
    refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL slt_lat got=%0d want=3", lat); end
    total++; if (aluOut !== 32'd1) begin bad++; $display("FAIL slt_neg_lt_pos got=%h want=1", aluOut); end
    i = mkR(0, 7, 6, 6'h2A); i.regWrite = 1'b0;
    refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (aluOut !== 32'd0) begin bad++; $display("FAIL slt_swapped got=%h want=0", aluOut); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL slt_swapped_zero got=%b want=1", zero); end
  endtask

  task automatic test_both_mem();
    instr_t i;
    logic [31:0] ea; logic ez; int el, lat;
    i = mkLw(9, 16'h0010); refExec(i, ea, ez, el); runOp(i, lat);
    i = mkLw(7, 16'h0020); i.memWrite = 1'b1;
    refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL both_lat got=%0d want=5", lat); end
    i = mkView(7); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (aluOut !== 32'hDEADBEEF) begin bad++; $display("FAIL both_wb_old_load got=%h want=deadbeef", aluOut); end
    i = mkLw(10, 16'h0020); refExec(i, ea, ez, el); runOp(i, lat);
    i = mkView(10); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (aluOut !== ea) begin bad++; $display("FAIL both_stored got=%h want=%h", aluOut, ea); end
    total++; if (aluOut !== 32'd1) begin bad++; $display("FAIL both_stored_const got=%h want=1", aluOut); end
  endtask

  task automatic test_busy_ignore();
    instr_t a, b;
    logic [31:0] ea, eb; logic ez, ezb; int el, elb, lat, dones, firstDone;
    a = mkR(13, 1, 2, 6'h22);
    b = mkAddi(14, 0, 16'h7777);
    refExec(a, ea, ez, el);
    dones = 0; firstDone = 0;
    startOp(a);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        if (firstDone == 0) firstDone = k;
      end
      if (k == 1) startOp(b);
      start = (k <= 2);
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", dones); end
    total++; if (firstDone !== el) begin bad++; $display("FAIL busy_lat got=%0d want=%0d", firstDone, el); end
    total++; if (aluOut !== ea) begin bad++; $display("FAIL busy_alu got=%h want=%h", aluOut, ea); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b want=0", busy); end
    refExec(mkView(14), eb, ezb, elb);
    runOp(mkView(14), lat);
    total++; if (aluOut !== eb) begin bad++; $display("FAIL busy_r14 got=%h want=%h", aluOut, eb); end
  endtask

  task automatic test_back_to_back();
    instr_t a, b;
    logic [31:0] ea, eb; logic ez, ezb; int el, elb, lat, lat2;
    a = mkAddi(11, 0, 16'h0123);
    b = mkR(12, 11, 11, 6'h20);
    refExec(a, ea, ez, el);
    refExec(b, eb, ezb, elb);
    runOp(a, lat);
    total++; if (lat !== el) begin bad++; $display("FAIL b2b_a_lat got=%0d want=%0d", lat, el); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_on_done got=%b want=0", busy); end
    startOp(b);
    @(negedge clk);
    start = 1'b0;
    lat2 = 1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
    while (done !== 1'b1 && lat2 < 20) begin
      @(negedge clk);
      lat2++;
    end
    total++; if (lat2 !== elb) begin bad++; $display("FAIL b2b_b_lat got=%0d want=%0d", lat2, elb); end
    total++; if (aluOut !== eb) begin bad++; $display("FAIL b2b_b_alu got=%h want=%h", aluOut, eb); end
    total++; if (aluOut !== 32'h246) begin bad++; $display("FAIL b2b_b_const got=%h want=246", aluOut); end
  endtask

  task automatic test_reset_mid();
    instr_t i;
    logic [31:0] ea; logic ez; int el, lat;
    i = mkAddi(8, 0, 16'h1234); refExec(i, ea, ez, el); runOp(i, lat);
    startOp(mkSw(8, 16'h0010));
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", done); end
    total++; if (aluOut !== 32'd0) begin bad++; $display("FAIL rmid_alu got=%h want=0", aluOut); end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    i = mkLw(5, 16'h0010); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL rmid_lw_lat got=%0d want=5", lat); end
    i = mkView(5); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (aluOut !== 32'hDEADBEEF) begin bad++; $display("FAIL rmid_word got=%h want=deadbeef", aluOut); end
    i = mkView(4); refExec(i, ea, ez, el); runOp(i, lat);
    total++; if (aluOut !== 32'd0) begin bad++; $display("FAIL rmid_regs_cleared got=%h want=0", aluOut); end
  endtask

  task automatic test_random();
    logic [5:0] funcs [8];
    instr_t i;
    logic [31:0] ea; logic ez; int el, lat, kind, w;
    funcs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21, 6'h00};
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 5));
      w = 32 + int'($urandom_range(0, 7));
      case (kind)
        0: i = mkAddi(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)), 16'($urandom));
        1: begin
          i = mkR(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  funcs[$urandom_range(0, 7)]);
          i.regWrite = 1'($urandom);
        end
        2: begin
          i = mkAddi(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)), 16'($urandom));
          i.aluOp = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
          i.aluSrc = 1'($urandom);
        end
        3: i = mkSw(int'($urandom_range(0, 7)), 16'(w * 4 + int'($urandom_range(0, 3))));
        default: begin
          if (memValid[w]) i = mkLw(int'($urandom_range(1, 7)), 16'(w * 4 + int'($urandom_range(0, 3))));
          else i = mkSw(int'($urandom_range(1, 7)), 16'(w * 4));
        end
      endcase
      refExec(i, ea, ez, el);
      runOp(i, lat);
      total++; if (lat !== el) begin bad++; $display("FAIL rand_lat n%0d got=%0d want=%0d", n, lat, el); end
      total++; if (aluOut !== ea) begin bad++; $display("FAIL rand_alu n%0d got=%h want=%h", n, aluOut, ea); end
      total++; if (zero !== ez) begin bad++; $display("FAIL rand_zero n%0d got=%b want=%b", n, zero, ez); end
    end
    for (int r = 1; r < 8; r++) begin
      refExec(mkView(r), ea, ez, el);
      runOp(mkView(r), lat);
      total++; if (aluOut !== ea) begin bad++; $display("FAIL rand_reg r%0d got=%h want=%h", r, aluOut, ea); end
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      refMem[k] = 32'd0;
      memValid[k] = 1'b0;
    end
    modelReset();
    test_reset();
    test_rtype_add();
    test_r0_write();
    test_store_load();
    test_slt();
    test_both_mem();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
